// File: rtl/cache_fill_fsm_pkg.sv
// Shared constants, state encoding and helpers for the cache miss fill handler.
package cache_fill_fsm_pkg;

  localparam int WORDS_PER_BLOCK   = 8;
  localparam int BLOCK_OFFSET_BITS = 4;
  localparam int MEM_LATENCY       = 4;
  localparam int DATA_W            = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FILL = 2'b01,
    ST_WAIT = 2'b10
  } fill_state_e;

  // One-hot word select; callers truncate to the block width.
  function automatic logic [31:0] word_onehot(input logic [4:0] idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Miss/memory/data-array signal bundle seen by one fill handler.
// master = the fill FSM, slave = the surrounding cache and memory interface.
interface cache_fill_if #(
  parameter int ADDR_W = 16,
  parameter int WORDS  = 8
);
  logic              miss_detected;
  logic [ADDR_W-1:0] miss_addr;
  logic              grant;
  logic              mem_data_valid;
  logic [15:0]       mem_data_in;
  logic              fsm_busy;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              data_wr_en;
  logic [WORDS-1:0]  data_wr_word;
  logic              tag_wr_en;

  modport master (
    input  miss_detected, miss_addr, grant, mem_data_valid, mem_data_in,
    output fsm_busy, mem_req, mem_addr, data_wr_en, data_wr_word, tag_wr_en
  );

  modport slave (
    output miss_detected, miss_addr, grant, mem_data_valid, mem_data_in,
    input  fsm_busy, mem_req, mem_addr, data_wr_en, data_wr_word, tag_wr_en
  );
endinterface

// File: rtl/cache_fill_fsm_fill_counter.sv
// Saturation-free up-counter used for issued and received word counts.
// Width is one bit wider than the word index so a full block is representable.
module fill_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {W{1'b0}};
    end else if (inc) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill handler: issues one word address per granted cycle and
// steers each in-order returned word into the data array, writing the tag
// together with the last word of the block.
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int WORDS  = WORDS_PER_BLOCK,
  parameter int ADDR_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  cache_fill_if.master bus
);

  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam int OFF_W = IDX_W + 1;          // word index plus byte-in-word bit
  localparam int BLK_W = ADDR_W - OFF_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS);

  fill_state_e       state_q;
  fill_state_e       state_d;
  logic              state_wen_s;
  logic [BLK_W-1:0]  blk_q;
  logic [BLK_W-1:0]  blk_d;
  logic [CNT_W-1:0]  issue_cnt_s;
  logic [CNT_W-1:0]  recv_cnt_s;
  logic              active_s;
  logic              issue_inc_s;
  logic              recv_inc_s;
  logic              done_s;

  fill_counter #(.W(CNT_W)) u_issue_cnt (
    .clk (clk),
    .rst (rst),
    .clr (done_s),
    .inc (issue_inc_s),
    .cnt (issue_cnt_s)
  );

  fill_counter #(.W(CNT_W)) u_recv_cnt (
    .clk (clk),
    .rst (rst),
    .clr (done_s),
    .inc (recv_inc_s),
    .cnt (recv_cnt_s)
  );

  // Qualify issue and return events; returns in IDLE are dropped and the
  // receive count never advances past a full block.
  always_comb begin
    active_s    = (state_q != ST_IDLE);
    issue_inc_s = (state_q == ST_FILL) && bus.grant;
    recv_inc_s  = active_s && bus.mem_data_valid && (recv_cnt_s != CNT_FULL);
    done_s      = recv_inc_s && (recv_cnt_s == CNT_LAST);
  end

  // State and latched block address registers; the block address only
  // loads when a miss is accepted, so it is held for the whole fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      blk_q   <= {BLK_W{1'b0}};
    end else if (state_wen_s) begin
      state_q <= state_d;
      blk_q   <= blk_d;
    end else begin
      state_q <= state_q;
      blk_q   <= blk_q;
    end
  end

  // Next-state logic; a miss seen outside IDLE is ignored.
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.miss_detected) begin
          state_d = ST_FILL;
          blk_d   = bus.miss_addr[ADDR_W-1:OFF_W];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (done_s) begin
          state_d = ST_IDLE;
        end else if (issue_inc_s && (issue_cnt_s == CNT_LAST)) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_WAIT: begin
        if (done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    state_wen_s = (state_d != state_q) || (blk_d != blk_q);
  end

  // Output decode; busy includes the miss cycle so the pipeline stalls at once.
  always_comb begin
    bus.fsm_busy     = active_s || bus.miss_detected;
    bus.mem_req      = 1'b0;
    bus.mem_addr     = {ADDR_W{1'b0}};
    bus.data_wr_en   = recv_inc_s;
    bus.data_wr_word = {WORDS{1'b0}};
    bus.tag_wr_en    = done_s;
    if (state_q == ST_FILL) begin
      bus.mem_req  = 1'b1;
      bus.mem_addr = {blk_q, issue_cnt_s[IDX_W-1:0], 1'b0};
    end else begin
      bus.mem_req  = 1'b0;
    end
    if (recv_inc_s) begin
      bus.data_wr_word = WORDS'(word_onehot(5'(recv_cnt_s[IDX_W-1:0])));
    end else begin
      bus.data_wr_word = {WORDS{1'b0}};
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: a vector table for the clean fill plus
// scoreboarded sequences for grant gaps, ignored misses, reset and back-to-back.
module tb_cache_fill_fsm;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  cache_fill_if #(.ADDR_W(16), .WORDS(8)) bus ();

  cache_fill_fsm #(.WORDS(8), .ADDR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        m;
    logic        g;
    logic        v;
    logic        busy;
    logic        req;
    logic [15:0] addr;
    logic        wr;
    logic [7:0]  word;
    logic        tag;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(input logic m, input logic g, input logic v,
                              input logic busy, input logic req, input logic [15:0] addr,
                              input logic wr, input logic [7:0] word, input logic tag);
    vec_t r;
    r.m = m; r.g = g; r.v = v; r.busy = busy; r.req = req;
    r.addr = addr; r.wr = wr; r.word = word; r.tag = tag;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drive inputs just after a rising edge, then settle before sampling.
  task automatic drive(input logic r, input logic m, input logic [15:0] a,
                       input logic g, input logic v);
    @(posedge clk);
    #1;
    rst                = r;
    bus.miss_detected  = m;
    bus.miss_addr      = a;
    bus.grant          = g;
    bus.mem_data_valid = v;
    bus.mem_data_in    = 16'hA55A;
    #3;
  endtask

  task automatic chk_all(input string nm, input logic busy, input logic req,
                         input logic [15:0] addr, input logic wr,
                         input logic [7:0] word, input logic tag);
    chk({nm, ".busy"}, 32'(bus.fsm_busy), 32'(busy));
    chk({nm, ".req"},  32'(bus.mem_req), 32'(req));
    chk({nm, ".addr"}, 32'(bus.mem_addr), 32'(addr));
    chk({nm, ".wr"},   32'(bus.data_wr_en), 32'(wr));
    chk({nm, ".word"}, 32'(bus.data_wr_word), 32'(word));
    chk({nm, ".tag"},  32'(bus.tag_wr_en), 32'(tag));
  endtask

  // Full fill with a scoreboard: returns come 5 cycles after each issue.
  task automatic run_fill(input string nm, input logic [15:0] a,
                          input int gap_at, input int gap_len,
                          input int mid_cyc, input logic [15:0] mid_addr,
                          input bit hold_end, input logic [15:0] next_addr);
    int issued;
    int recv;
    int due[$];
    bit done;
    logic g;
    logic v;
    logic m;
    logic [15:0] ma;
    logic [15:0] base;
    issued = 0;
    recv   = 0;
    done   = 1'b0;
    base   = {a[15:4], 4'h0};
    drive(1'b0, 1'b1, a, 1'b1, 1'b0);
    chk({nm, ".miss_busy"}, 32'(bus.fsm_busy), 32'd1);
    chk({nm, ".miss_req"},  32'(bus.mem_req), 32'd0);
    for (int c = 1; c <= 60 && !done; c++) begin
      g  = !(c > gap_at && c <= gap_at + gap_len);
      v  = (due.size() > 0) && (due[0] == c);
      m  = 1'b0;
      ma = a;
      if (c == mid_cyc) begin
        m  = 1'b1;
        ma = mid_addr;
      end
      if (hold_end && v && recv == 7) begin
        m  = 1'b1;
        ma = next_addr;
      end
      drive(1'b0, m, ma, g, v);
      chk({nm, ".busy"}, 32'(bus.fsm_busy), 32'd1);
      if (issued < 8) begin
        chk({nm, ".req"},  32'(bus.mem_req), 32'd1);
        chk({nm, ".addr"}, 32'(bus.mem_addr), 32'(base + 16'(2 * issued)));
      end else begin
        chk({nm, ".req_wait"}, 32'(bus.mem_req), 32'd0);
      end
      chk({nm, ".wr"}, 32'(bus.data_wr_en), 32'(v));
      if (v) begin
        chk({nm, ".word"}, 32'(bus.data_wr_word), 32'd1 << recv);
      end
      chk({nm, ".tag"}, 32'(bus.tag_wr_en), 32'(v && recv == 7));
      if (issued < 8 && g) begin
        due.push_back(c + 5);
        issued++;
      end
      if (v) begin
        void'(due.pop_front());
        recv++;
        if (recv == 8) done = 1'b1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s.timeout: got %0d words expected 8", nm, recv);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.miss_detected  = 1'b0;
    bus.miss_addr      = 16'h0000;
    bus.grant          = 1'b0;
    bus.mem_data_valid = 1'b0;
    bus.mem_data_in    = 16'h0000;

    // Reset state
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk_all("reset", 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);

    // Clean fill, grant held high, miss 0x1234 at row 0
    tbl[0]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1230, 1'b0, 8'h00, 1'b0);
    tbl[2]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1232, 1'b0, 8'h00, 1'b0);
    tbl[3]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 8'h00, 1'b0);
    tbl[4]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1236, 1'b0, 8'h00, 1'b0);
    tbl[5]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1238, 1'b0, 8'h00, 1'b0);
    tbl[6]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h123A, 1'b1, 8'h01, 1'b0);
    tbl[7]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h123C, 1'b1, 8'h02, 1'b0);
    tbl[8]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h123E, 1'b1, 8'h04, 1'b0);
    tbl[9]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h08, 1'b0);
    tbl[10] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h10, 1'b0);
    tbl[11] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h20, 1'b0);
    tbl[12] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h40, 1'b0);
    tbl[13] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h80, 1'b1);
    tbl[14] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, tbl[i].m, 16'h1234, tbl[i].g, tbl[i].v);
      chk_all($sformatf("clean[%0d]", i), tbl[i].busy, tbl[i].req, tbl[i].addr,
              tbl[i].wr, tbl[i].word, tbl[i].tag);
    end

    // Grant drops for 3 cycles after the third issue
    run_fill("gap", 16'h1234, 3, 3, -1, 16'h0000, 1'b0, 16'h0000);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk_all("gap_end", 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);

    // Second miss mid-fill ignored; new miss right after completion accepted
    run_fill("midmiss", 16'h1234, 0, 0, 4, 16'h4000, 1'b0, 16'h0000);
    run_fill("after", 16'h4000, 0, 0, -1, 16'h0000, 1'b0, 16'h0000);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk_all("after_end", 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);

    // Back-to-back: miss held at completion keeps busy high continuously
    run_fill("b2b_a", 16'h1234, 0, 0, -1, 16'h0000, 1'b1, 16'h4000);
    run_fill("b2b_b", 16'h4000, 0, 0, -1, 16'h0000, 1'b0, 16'h0000);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk_all("b2b_end", 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);

    // Reset two cycles after the first return
    drive(1'b0, 1'b1, 16'h1234, 1'b1, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      drive(1'b0, 1'b0, 16'h1234, 1'b1, (c >= 6));
      if (c == 6) chk("rst_seq.word0", 32'(bus.data_wr_word), 32'h01);
      if (c == 7) chk("rst_seq.word1", 32'(bus.data_wr_word), 32'h02);
    end
    drive(1'b1, 1'b0, 16'h1234, 1'b1, 1'b1);
    for (int c = 9; c <= 13; c++) begin
      drive(1'b0, 1'b0, 16'h1234, 1'b1, 1'b1);
      chk_all($sformatf("rst_late[%0d]", c), 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
    end

    // Valid pulses while IDLE cause no writes; counters stay at 0
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
      chk_all($sformatf("idle_valid[%0d]", c), 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
    end
    run_fill("post_idle", 16'h2468, 0, 0, -1, 16'h0000, 1'b0, 16'h0000);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk_all("final", 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
